// File: rtl/pipe_stage_elastic_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic_pkg : shared pipeline-stage state encoding and stage widths
// Revision 1.0
// ============================================================================
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_e;

  localparam int IF_ID_BITS  = 64;
  localparam int ID_EX_BITS  = 196;
  localparam int EX_MEM_BITS = 137;
  localparam int MEM_WB_BITS = 71;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic_if : upstream/downstream valid-ready handshake of a stage
// Revision 1.0
// ============================================================================
interface pipe_stage_elastic_if #(
  parameter int N_BITS = 64
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [N_BITS-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [N_BITS-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, clear has priority
// Revision 1.0
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : elastic pipeline register with flush, optional skid
//                      buffer and saturating stall counter
// Revision 1.0
// ============================================================================
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int N_BITS   = 64,
  parameter int SKID     = 1,
  parameter int CNT_BITS = 16
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                flush_i,
  pipe_stage_elastic_if.slave      bus,
  input  wire logic                cnt_clr_i,
  output logic      [CNT_BITS-1:0] stall_cnt_o
);

  pipe_state_e       r_state;
  pipe_state_e       w_next_state;
  logic [N_BITS-1:0] r_main;
  logic [N_BITS-1:0] w_skid_q;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_emit;
  logic              w_load_main;
  logic              w_main_from_skid;
  logic              w_stall;

  assign w_out_valid = (r_state != PIPE_EMPTY);
  assign w_accept    = bus.in_valid_i & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready_i;

  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = r_main;
  assign bus.in_ready_o  = w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PIPE_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Main register only loads on a real accept, so idle X on in_data_i never lands here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
    end else if (flush_i) begin
      r_main <= '0;
    end else if (w_load_main) begin
      r_main <= w_main_from_skid ? w_skid_q : bus.in_data_i;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [N_BITS-1:0] r_skid;
      logic              r_in_ready;
      logic              w_load_skid;

      always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
          w_next_state = PIPE_EMPTY;
        end else begin
          case (r_state)
            PIPE_EMPTY: begin
              if (w_accept) begin
                w_next_state = PIPE_FULL;
                w_load_main  = 1'b1;
              end
            end
            PIPE_FULL: begin
              if (w_accept && w_emit) begin
                w_load_main = 1'b1;
              end else if (w_emit) begin
                w_next_state = PIPE_EMPTY;
              end else if (w_accept) begin
                w_next_state = PIPE_SKID;
                w_load_skid  = 1'b1;
              end
            end
            PIPE_SKID: begin
              if (w_emit) begin
                w_next_state     = PIPE_FULL;
                w_load_main      = 1'b1;
                w_main_from_skid = 1'b1;
              end
            end
            default: w_next_state = PIPE_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_skid <= '0;
        end else if (flush_i) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= bus.in_data_i;
        end
      end

      // Registered from next state so out_ready_i never reaches in_ready_o combinationally.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_next_state != PIPE_SKID);
        end
      end

      assign w_in_ready = r_in_ready;
      assign w_skid_q   = r_skid;
    end else begin : g_noskid
      always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush_i) begin
          w_next_state = PIPE_EMPTY;
        end else if (w_accept) begin
          w_next_state = PIPE_FULL;
          w_load_main  = 1'b1;
        end else if (w_emit) begin
          w_next_state = PIPE_EMPTY;
        end
      end

      assign w_in_ready = !w_out_valid | bus.out_ready_i;
      assign w_skid_q   = '0;
    end
  endgenerate

  assign w_stall = w_out_valid & !bus.out_ready_i & !flush_i;

  sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_i),
    .inc   (w_stall),
    .count (stall_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_elastic : drives a SKID=1 and a SKID=0 stage with shared stimulus
// Revision 1.0
// ============================================================================
module tb_pipe_stage_elastic;

  localparam int NB = 64;
  localparam int CB = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          flush     = 1'b0;
  logic          cnt_clr   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [NB-1:0] in_data   = '0;
  logic [CB-1:0] cnt1;
  logic [CB-1:0] cnt0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.N_BITS(NB)) bus1 ();
  pipe_stage_elastic_if #(.N_BITS(NB)) bus0 ();

  assign bus1.in_valid_i  = in_valid;
  assign bus1.in_data_i   = in_data;
  assign bus1.out_ready_i = out_ready;
  assign bus0.in_valid_i  = in_valid;
  assign bus0.in_data_i   = in_data;
  assign bus0.out_ready_i = out_ready;

  pipe_stage_elastic #(.N_BITS(NB), .SKID(1), .CNT_BITS(CB)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .bus         (bus1),
    .cnt_clr_i   (cnt_clr),
    .stall_cnt_o (cnt1)
  );

  pipe_stage_elastic #(.N_BITS(NB), .SKID(0), .CNT_BITS(CB)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .bus         (bus0),
    .cnt_clr_i   (cnt_clr),
    .stall_cnt_o (cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] got;
    reset = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 64'd77; out_ready = 1'b0;
    tick();
    tick();
    // asynchronous: assert mid-cycle and look before the next edge
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
      cnt_clr = 1'($urandom); in_data = {$urandom, $urandom};
      #1;
      got = {bus1.out_valid_o, bus1.in_ready_o, cnt1, 1'b0};
      n_cmp++;
      if (got !== 7'b0100000) begin
        n_err++; $display("FAIL reset_ctl1[%0d]: got %b want 0100000", k, got);
      end
      n_cmp++;
      if (bus1.out_data_o !== 64'd0) begin
        n_err++; $display("FAIL reset_data1[%0d]: got %0h want 0", k, bus1.out_data_o);
      end
      n_cmp++;
      if ({bus0.out_valid_o, bus0.in_ready_o, cnt0} !== 6'b010000) begin
        n_err++; $display("FAIL reset_ctl0[%0d]: got %b%b%b want 010000", k,
                          bus0.out_valid_o, bus0.in_ready_o, cnt0);
      end
      n_cmp++;
      if (bus0.out_data_o !== 64'd0) begin
        n_err++; $display("FAIL reset_data0[%0d]: got %0h want 0", k, bus0.out_data_o);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    #1 reset = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 64'hA5) begin
      n_err++; $display("FAIL first_accept1: got v=%b d=%0h want v=1 d=a5", bus1.out_valid_o, bus1.out_data_o);
    end
    n_cmp++;
    if (bus0.out_valid_o !== 1'b1 || bus0.out_data_o !== 64'hA5) begin
      n_err++; $display("FAIL first_accept0: got v=%b d=%0h want v=1 d=a5", bus0.out_valid_o, bus0.out_data_o);
    end
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 101; i++) begin
      in_valid = (i < 100);
      in_data  = 64'(i);
      #1;
      if (i >= 1 && i <= 100) begin
        n_cmp++;
        if (bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 64'(i - 1) || bus1.in_ready_o !== 1'b1) begin
          n_err++; $display("FAIL stream1[%0d]: got v=%b d=%0d r=%b want v=1 d=%0d r=1", i,
                            bus1.out_valid_o, bus1.out_data_o, bus1.in_ready_o, i - 1);
        end
        n_cmp++;
        if (bus0.out_valid_o !== 1'b1 || bus0.out_data_o !== 64'(i - 1) || bus0.in_ready_o !== 1'b1) begin
          n_err++; $display("FAIL stream0[%0d]: got v=%b d=%0d r=%b want v=1 d=%0d r=1", i,
                            bus0.out_valid_o, bus0.out_data_o, bus0.in_ready_o, i - 1);
        end
      end else if (i == 101) begin
        n_cmp++;
        if (bus1.out_valid_o !== 1'b0 || bus0.out_valid_o !== 1'b0) begin
          n_err++; $display("FAIL stream_drain: got v1=%b v0=%b want 0 0", bus1.out_valid_o, bus0.out_valid_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h1;
    #1;
    n_cmp++;
    if (bus1.in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_ready0: got %b want 1", bus1.in_ready_o);
    end
    tick();
    in_data = 64'h2;
    #1;
    n_cmp++;
    if (bus1.in_ready_o !== 1'b1 || bus1.out_data_o !== 64'h1) begin
      n_err++; $display("FAIL bp_full: got r=%b d=%0h want r=1 d=1", bus1.in_ready_o, bus1.out_data_o);
    end
    tick();
    in_data = 64'h3;
    #1;
    n_cmp++;
    if (bus1.in_ready_o !== 1'b0 || bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 64'h1) begin
      n_err++; $display("FAIL bp_skid: got r=%b v=%b d=%0h want r=0 v=1 d=1",
                        bus1.in_ready_o, bus1.out_valid_o, bus1.out_data_o);
    end
    tick();
    #1;
    n_cmp++;
    if (bus1.in_ready_o !== 1'b0 || bus1.out_data_o !== 64'h1) begin
      n_err++; $display("FAIL bp_hold: got r=%b d=%0h want r=0 d=1", bus1.in_ready_o, bus1.out_data_o);
    end
    n_cmp++;
    if (cnt1 !== 4'd2) begin
      n_err++; $display("FAIL bp_cnt: got %0d want 2", cnt1);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 64'h2 || bus1.in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_emit2: got v=%b d=%0h r=%b want v=1 d=2 r=1",
                        bus1.out_valid_o, bus1.out_data_o, bus1.in_ready_o);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 64'h3) begin
      n_err++; $display("FAIL bp_emit3: got v=%b d=%0h want v=1 d=3", bus1.out_valid_o, bus1.out_data_o);
    end
    tick();
    n_cmp++;
    if (bus1.out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL bp_empty: got v=%b want 0", bus1.out_valid_o);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h1;
    tick();
    in_data = 64'h2;
    tick();
    n_cmp++;
    if (bus1.in_ready_o !== 1'b0 || cnt1 !== 4'd1) begin
      n_err++; $display("FAIL flush_pre: got r=%b cnt=%0d want r=0 cnt=1", bus1.in_ready_o, cnt1);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (bus1.out_valid_o !== 1'b0 || bus1.out_data_o !== 64'd0 || bus1.in_ready_o !== 1'b1 || cnt1 !== 4'd1) begin
      n_err++; $display("FAIL flush1: got v=%b d=%0h r=%b cnt=%0d want v=0 d=0 r=1 cnt=1",
                        bus1.out_valid_o, bus1.out_data_o, bus1.in_ready_o, cnt1);
    end
    n_cmp++;
    if (bus0.out_valid_o !== 1'b0 || bus0.out_data_o !== 64'd0 || bus0.in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush0: got v=%b d=%0h r=%b want v=0 d=0 r=1",
                        bus0.out_valid_o, bus0.out_data_o, bus0.in_ready_o);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      tick();
      n_cmp++;
      if (bus1.out_valid_o !== 1'b0 || bus0.out_valid_o !== 1'b0) begin
        n_err++; $display("FAIL flush_no_emit[%0d]: got v1=%b v0=%b want 0 0", k,
                          bus1.out_valid_o, bus0.out_valid_o);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    logic [CB-1:0] want;
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h55;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      want = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      n_cmp++;
      if (cnt1 !== want || cnt0 !== want) begin
        n_err++; $display("FAIL sat[%0d]: got c1=%0d c0=%0d want %0d", k, cnt1, cnt0, want);
      end
      tick();
    end
    n_cmp++;
    if (cnt1 !== 4'd15 || cnt0 !== 4'd15) begin
      n_err++; $display("FAIL sat_hold: got c1=%0d c0=%0d want 15", cnt1, cnt0);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++;
    if (cnt1 !== 4'd0 || cnt0 !== 4'd0) begin
      n_err++; $display("FAIL sat_clr: got c1=%0d c0=%0d want 0", cnt1, cnt0);
    end
    tick();
    n_cmp++;
    if (cnt1 !== 4'd1 || cnt0 !== 4'd1) begin
      n_err++; $display("FAIL sat_after_clr: got c1=%0d c0=%0d want 1", cnt1, cnt0);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] q1[$];
    logic [NB-1:0] q0[$];
    logic [CB-1:0] m_cnt1;
    logic [CB-1:0] m_cnt0;
    logic          exp_rdy1, exp_rdy0, acc1, acc0, em1, em0, st1, st0;
    apply_reset();
    m_cnt1 = '0;
    m_cnt0 = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(63) == 0);
      cnt_clr   = ($urandom_range(99) == 0);
      in_data   = in_valid ? {$urandom, $urandom} : 'x;
      #1;
      exp_rdy1 = (q1.size() < 2);
      exp_rdy0 = (q0.size() == 0) || out_ready;
      n_cmp++;
      if (bus1.in_ready_o !== exp_rdy1 || bus1.out_valid_o !== (q1.size() != 0) || cnt1 !== m_cnt1) begin
        n_err++; $display("FAIL rnd_ctl1[%0d]: got r=%b v=%b c=%0d want r=%b v=%b c=%0d", c,
                          bus1.in_ready_o, bus1.out_valid_o, cnt1, exp_rdy1, q1.size() != 0, m_cnt1);
      end
      n_cmp++;
      if (bus0.in_ready_o !== exp_rdy0 || bus0.out_valid_o !== (q0.size() != 0) || cnt0 !== m_cnt0) begin
        n_err++; $display("FAIL rnd_ctl0[%0d]: got r=%b v=%b c=%0d want r=%b v=%b c=%0d", c,
                          bus0.in_ready_o, bus0.out_valid_o, cnt0, exp_rdy0, q0.size() != 0, m_cnt0);
      end
      if (q1.size() != 0) begin
        n_cmp++;
        if (bus1.out_data_o !== q1[0]) begin
          n_err++; $display("FAIL rnd_data1[%0d]: got %0h want %0h", c, bus1.out_data_o, q1[0]);
        end
      end
      if (q0.size() != 0) begin
        n_cmp++;
        if (bus0.out_data_o !== q0[0]) begin
          n_err++; $display("FAIL rnd_data0[%0d]: got %0h want %0h", c, bus0.out_data_o, q0[0]);
        end
      end
      // wiggle out_ready mid-cycle: the skid variant's in_ready must not follow it
      out_ready = ~out_ready;
      #1;
      n_cmp++;
      if (bus1.in_ready_o !== exp_rdy1) begin
        n_err++; $display("FAIL rnd_ready_comb[%0d]: got %b want %b", c, bus1.in_ready_o, exp_rdy1);
      end
      out_ready = ~out_ready;
      #1;
      acc1 = in_valid && exp_rdy1;
      acc0 = in_valid && exp_rdy0;
      em1  = (q1.size() != 0) && out_ready;
      em0  = (q0.size() != 0) && out_ready;
      st1  = (q1.size() != 0) && !out_ready && !flush;
      st0  = (q0.size() != 0) && !out_ready && !flush;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (em1) void'(q1.pop_front());
        if (acc1) q1.push_back(in_data);
        if (em0) void'(q0.pop_front());
        if (acc0) q0.push_back(in_data);
      end
      if (cnt_clr) m_cnt1 = '0;
      else if (st1 && m_cnt1 != 4'hF) m_cnt1 = m_cnt1 + 4'd1;
      if (cnt_clr) m_cnt0 = '0;
      else if (st0 && m_cnt0 != 4'hF) m_cnt0 = m_cnt0 + 4'd1;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
